// File: rtl/output_gain_stage.sv
// Output gain stage: Q2.14 gain on 16-bit signed samples with round-half-up, saturation and a held clip LED.
// Optional macro GAIN_RAMP_EN: slew the applied gain toward the target by at most RAMP_STEP per sample.
module output_gain_stage #(
    parameter int GW        = 16,
    parameter int FRAC      = 14,
    parameter int RAMP_STEP = 64,
    parameter int CLIP_HOLD = 4800
) (
    input  logic                 clk_144,
    input  logic                 reset_n,
    input  logic signed [15:0]   gainIn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic        [GW-1:0] target_gain,
    input  logic                 mute,
    output logic signed [15:0]   gainOut,
    output logic                 out_valid,
    output logic                 clip,
    output logic                 clip_led
);

    localparam int DW = 16;
    localparam int PW = DW + GW + 1;
    localparam int HW = $clog2(CLIP_HOLD + 1);

    localparam logic signed [PW-1:0] ROUND_C   = PW'(1) <<< (FRAC - 1);
    localparam logic signed [PW-1:0] SAT_MAX   = PW'(32'sd32767);
    localparam logic signed [PW-1:0] SAT_MIN   = PW'(-32'sd32768);
    localparam logic        [HW-1:0] HOLD_INIT = HW'(CLIP_HOLD);
    localparam logic        [HW-1:0] HOLD_ONE  = HW'(1);
    localparam logic        [GW-1:0] STEP_G    = GW'(RAMP_STEP);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_SAT  = 2'd2
    } state_t;

    // Returns {saturated_flag, clamped 16-bit value}.
    function automatic logic [DW:0] saturate(input logic signed [PW-1:0] v);
        logic [DW:0] res;
        if (v > SAT_MAX) begin
            res = {1'b1, 16'h7FFF};
        end else if (v < SAT_MIN) begin
            res = {1'b1, 16'h8000};
        end else begin
            res = {1'b0, v[DW-1:0]};
        end
        return res;
    endfunction

    // One slew step toward tgt; the final step lands exactly on tgt, so no overshoot or wrap.
    function automatic logic [GW-1:0] ramp_toward(input logic [GW-1:0] cur, input logic [GW-1:0] tgt);
        logic [GW-1:0] res;
        if (tgt >= cur) begin
            if ((tgt - cur) <= STEP_G) begin
                res = tgt;
            end else begin
                res = cur + STEP_G;
            end
        end else begin
            if ((cur - tgt) <= STEP_G) begin
                res = tgt;
            end else begin
                res = cur - STEP_G;
            end
        end
        return res;
    endfunction

    state_t                 state_q,     state_d;
    logic signed [DW-1:0]   sample_q,    sample_d;
    logic        [GW-1:0]   target_q,    target_d;
    logic        [GW-1:0]   cur_gain_q,  cur_gain_d;
    logic signed [PW-1:0]   product_q,   product_d;
    logic signed [DW-1:0]   gain_out_q,  gain_out_d;
    logic                   out_valid_q, out_valid_d;
    logic                   clip_q,      clip_d;
    logic        [HW-1:0]   hold_q,      hold_d;
    logic                   led_q,       led_d;
    logic                   in_ready_q,  in_ready_d;

    logic signed [PW-1:0]   s_ext_s;
    logic signed [PW-1:0]   g_ext_s;
    logic signed [PW-1:0]   round_sum_s;
    logic signed [PW-1:0]   rounded_s;
    logic        [DW:0]     sat_s;

    // Sample is sign-extended, gain zero-extended, so the product never overflows PW bits.
    assign s_ext_s     = {{(PW-DW){sample_q[DW-1]}}, sample_q};
    assign g_ext_s     = {{(PW-GW){1'b0}}, cur_gain_q};
    assign round_sum_s = product_q + ROUND_C;
    assign rounded_s   = round_sum_s >>> FRAC;
    assign sat_s       = saturate(rounded_s);

    // State and datapath registers.
    always_ff @(posedge clk_144 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            sample_q    <= {DW{1'b0}};
            target_q    <= {GW{1'b0}};
            cur_gain_q  <= {GW{1'b0}};
            product_q   <= {PW{1'b0}};
            gain_out_q  <= {DW{1'b0}};
            out_valid_q <= 1'b0;
            clip_q      <= 1'b0;
            hold_q      <= {HW{1'b0}};
            led_q       <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            sample_q    <= sample_d;
            target_q    <= target_d;
            cur_gain_q  <= cur_gain_d;
            product_q   <= product_d;
            gain_out_q  <= gain_out_d;
            out_valid_q <= out_valid_d;
            clip_q      <= clip_d;
            hold_q      <= hold_d;
            led_q       <= led_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Next-state and datapath update for the IDLE -> MUL -> SAT cadence.
    always_comb begin
        state_d     = state_q;
        sample_d    = sample_q;
        target_d    = target_q;
        cur_gain_d  = cur_gain_q;
        product_d   = product_q;
        gain_out_d  = gain_out_q;
        out_valid_d = 1'b0;
        clip_d      = 1'b0;
        hold_d      = hold_q;
        led_d       = (hold_q != {HW{1'b0}});
        in_ready_d  = in_ready_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sample_d   = gainIn;
                    target_d   = mute ? {GW{1'b0}} : target_gain;
                    state_d    = ST_MUL;
                    in_ready_d = 1'b0;
                end else begin
                    state_d    = ST_IDLE;
                    in_ready_d = 1'b1;
                end
            end
            ST_MUL: begin
                product_d  = s_ext_s * g_ext_s;
                state_d    = ST_SAT;
                in_ready_d = 1'b0;
            end
            ST_SAT: begin
                gain_out_d  = sat_s[DW-1:0];
                out_valid_d = 1'b1;
                clip_d      = sat_s[DW];
`ifdef GAIN_RAMP_EN
                cur_gain_d  = ramp_toward(cur_gain_q, target_q);
`else
                cur_gain_d  = target_q;
`endif
                if (sat_s[DW]) begin
                    hold_d = HOLD_INIT;
                end else if (hold_q != {HW{1'b0}}) begin
                    hold_d = hold_q - HOLD_ONE;
                end else begin
                    hold_d = hold_q;
                end
                state_d    = ST_IDLE;
                in_ready_d = 1'b1;
            end
            default: begin
                state_d    = ST_IDLE;
                in_ready_d = 1'b1;
            end
        endcase
    end

    assign in_ready  = in_ready_q;
    assign gainOut   = gain_out_q;
    assign out_valid = out_valid_q;
    assign clip      = clip_q;
    assign clip_led  = led_q;

endmodule

// File: tb/tb_output_gain_stage.sv
// Randomized, self-checking bench for output_gain_stage against an arithmetic reference model.
module tb_output_gain_stage;

    localparam int HOLD = 4800;
    localparam int STEP = 64;
`ifdef GAIN_RAMP_EN
    localparam bit RAMP = 1'b1;
`else
    localparam bit RAMP = 1'b0;
`endif

    logic               clk_144 = 1'b0;
    logic               reset_n;
    logic signed [15:0] gainIn;
    logic               in_valid;
    logic               in_ready;
    logic        [15:0] target_gain;
    logic               mute;
    logic signed [15:0] gainOut;
    logic               out_valid;
    logic               clip;
    logic               clip_led;

    int checks = 0;
    int errors = 0;
    int m_gain;
    int m_idx;
    int m_last_clip;

    output_gain_stage dut (
        .clk_144     (clk_144),
        .reset_n     (reset_n),
        .gainIn      (gainIn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .target_gain (target_gain),
        .mute        (mute),
        .gainOut     (gainOut),
        .out_valid   (out_valid),
        .clip        (clip),
        .clip_led    (clip_led)
    );

    always #5 clk_144 = ~clk_144;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    // Reference: y = floor((s*g + 8192) / 16384) clamped to int16, then gain moves toward t.
    task automatic model_step(input int s, input int t, output int y, output bit c);
        longint p, num, q;
        int delta;
        p   = longint'(s) * longint'(m_gain);
        num = p + 64'sd8192;
        q   = num / 64'sd16384;
        if (num < 0 && q * 64'sd16384 != num) q = q - 1;
        c = 1'b0;
        if (q > 32767) begin
            y = 32767; c = 1'b1;
        end else if (q < -32768) begin
            y = -32768; c = 1'b1;
        end else begin
            y = int'(q);
        end
        if (RAMP) begin
            delta = t - m_gain;
            if (delta > STEP) m_gain = m_gain + STEP;
            else if (delta < -STEP) m_gain = m_gain - STEP;
            else m_gain = t;
        end else begin
            m_gain = t;
        end
        if (c) m_last_clip = m_idx;
        m_idx++;
    endtask

    function automatic bit model_led();
        return (m_last_clip >= 0) && ((m_idx - 1 - m_last_clip) < HOLD);
    endfunction

    task automatic model_reset();
        m_gain = 0; m_idx = 0; m_last_clip = -1;
    endtask

    // Drives one sample and observes the result; lat counts negedges from the drive edge to out_valid.
    task automatic send(input int s, input int t, input bit m, output int y, output bit c,
                        output bit led, output int lat, output bit pulse_ok);
        int n;
        @(negedge clk_144);
        n = 0;
        while (!in_ready && n < 8) begin
            @(negedge clk_144);
            n++;
        end
        gainIn = 16'(s); target_gain = 16'(t); mute = m; in_valid = 1'b1;
        @(negedge clk_144);
        in_valid = 1'b0;
        lat = -1; y = 0; c = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (out_valid) begin
                lat = k; y = int'(gainOut); c = clip;
                break;
            end
            @(negedge clk_144);
        end
        @(negedge clk_144);
        led = clip_led;
        pulse_ok = !out_valid && !clip;
    endtask

    task automatic prime(input int t);
        int y, lat, ey, n;
        bit c, led, p, ec;
        n = 0;
        while (m_gain != t && n < 1100) begin
            send(0, t, 1'b0, y, c, led, lat, p);
            model_step(0, t, ey, ec);
            n++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; gainIn = 16'sd0; target_gain = 16'd0; mute = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_144);
        checks++;
        if ({in_ready, out_valid, clip, clip_led, gainOut} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL reset_values: got rdy/ov/clip/led/out=%b%b%b%b/%0d required 1000/0",
                     in_ready, out_valid, clip, clip_led, gainOut);
        end
        reset_n = 1'b1;
        @(negedge clk_144);
        checks++;
        if ({in_ready, out_valid, clip, clip_led, gainOut} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL after_release: got rdy/ov/clip/led/out=%b%b%b%b/%0d required 1000/0",
                     in_ready, out_valid, clip, clip_led, gainOut);
        end
    endtask

    task automatic test_ramp();
        int y, ey, lat;
        bit c, ec, led, p;
        for (int i = 0; i < 520; i++) begin
            send(16384, 16384, (i >= 260), y, c, led, lat, p);
            model_step(16384, (i >= 260) ? 0 : 16384, ey, ec);
            checks++;
            if (y !== ey || c !== ec) begin
                errors++;
                $display("FAIL ramp sample %0d: got %0d clip %0b required %0d clip %0b", i, y, c, ey, ec);
            end
        end
    endtask

    task automatic test_unity();
        int y, ey, lat;
        bit c, ec, led, p;
        for (int i = 0; i < 2; i++) begin
            send(1000, 16384, 1'b0, y, c, led, lat, p);
            model_step(1000, 16384, ey, ec);
            checks++;
            if (y !== ey || c !== ec) begin
                errors++;
                $display("FAIL unity sample %0d: got %0d clip %0b required %0d clip %0b", i, y, c, ey, ec);
            end
            checks++;
            if (lat !== 3) begin
                errors++;
                $display("FAIL latency: got %0d negedges required 3", lat);
            end
            checks++;
            if (p !== 1'b1) begin
                errors++;
                $display("FAIL single_cycle_strobe: out_valid/clip still high one cycle later");
            end
        end
    endtask

    task automatic test_rounding();
        int ins[6]  = '{3, -3, -4, 1, 5, -5};
        int outs[6] = '{2, -1, -2, 1, 3, -2};
        int y, ey, lat;
        bit c, ec, led, p;
        prime(8192);
        for (int i = 0; i < 6; i++) begin
            send(ins[i], 8192, 1'b0, y, c, led, lat, p);
            model_step(ins[i], 8192, ey, ec);
            checks++;
            if (y !== outs[i] || c !== 1'b0) begin
                errors++;
                $display("FAIL rounding in=%0d: got %0d clip %0b required %0d clip 0", ins[i], y, c, outs[i]);
            end
        end
    endtask

    task automatic test_clip();
        int y, ey, lat;
        bit c, ec, led, p;
        prime(32768);
        send(20000, 32768, 1'b0, y, c, led, lat, p);
        model_step(20000, 32768, ey, ec);
        checks++;
        if (y !== 32767 || c !== 1'b1 || led !== 1'b1) begin
            errors++;
            $display("FAIL clip_pos: got %0d clip %0b led %0b required 32767 1 1", y, c, led);
        end
        send(-20000, 32768, 1'b0, y, c, led, lat, p);
        model_step(-20000, 32768, ey, ec);
        checks++;
        if (y !== -32768 || c !== 1'b1 || p !== 1'b1) begin
            errors++;
            $display("FAIL clip_neg: got %0d clip %0b pulse_ok %0b required -32768 1 1", y, c, p);
        end
        for (int k = 1; k <= HOLD; k++) begin
            send(0, 32768, 1'b0, y, c, led, lat, p);
            model_step(0, 32768, ey, ec);
            checks++;
            if (led !== model_led() || c !== 1'b0) begin
                errors++;
                $display("FAIL clip_hold after %0d samples: led %0b clip %0b required led %0b clip 0",
                         k, led, c, model_led());
            end
        end
    endtask

    task automatic test_handshake();
        int ey, hits;
        bit ec;
        @(negedge clk_144);
        gainIn = 16'sd100; target_gain = 16'd32768; mute = 1'b0; in_valid = 1'b1;
        model_step(100, 32768, ey, ec);
        @(negedge clk_144);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL hs_ready_c1: got %0b required 0", in_ready);
        end
        gainIn = 16'sd200;
        @(negedge clk_144);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL hs_c2: ready %0b out_valid %0b required 0 0", in_ready, out_valid);
        end
        gainIn = 16'sd300;
        @(negedge clk_144);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || int'(gainOut) !== ey) begin
            errors++;
            $display("FAIL hs_c3: ready %0b out_valid %0b out %0d required 1 1 %0d", in_ready, out_valid, gainOut, ey);
        end
        in_valid = 1'b0;
        hits = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_144);
            if (out_valid) hits++;
        end
        checks++;
        if (hits !== 0) begin
            errors++; $display("FAIL hs_extra_outputs: got %0d strobes required 0", hits);
        end
    endtask

    task automatic test_back_to_back();
        int exp_q[$];
        int s, t, y, ey;
        bit c, ev;
        for (int i = 0; i <= 30; i++) begin
            @(negedge clk_144);
            ev = (i % 3 == 0) && (i >= 3);
            checks++;
            if (out_valid !== ev) begin
                errors++; $display("FAIL b2b_valid cycle %0d: got %0b required %0b", i, out_valid, ev);
            end
            if (ev && exp_q.size() > 0) begin
                ey = exp_q.pop_front();
                checks++;
                if (int'(gainOut) !== ey) begin
                    errors++; $display("FAIL b2b_data cycle %0d: got %0d required %0d", i, gainOut, ey);
                end
            end
            checks++;
            if (in_ready !== (i % 3 == 0)) begin
                errors++; $display("FAIL b2b_ready cycle %0d: got %0b required %0b", i, in_ready, (i % 3 == 0));
            end
            if (i < 30) begin
                s = int'($urandom_range(0, 65535)) - 32768;
                t = int'($urandom_range(0, 65535));
                gainIn = 16'(s); target_gain = 16'(t); mute = 1'b0; in_valid = 1'b1;
                if (i % 3 == 0) begin
                    model_step(s, t, y, c);
                    exp_q.push_back(y);
                end
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_random();
        int s, t, y, ey, lat;
        bit m, c, ec, led, p;
        for (int i = 0; i < 200; i++) begin
            s = int'($urandom_range(0, 65535)) - 32768;
            t = int'($urandom_range(0, 65535));
            m = ($urandom_range(0, 7) == 0);
            send(s, t, m, y, c, led, lat, p);
            model_step(s, m ? 0 : t, ey, ec);
            checks++;
            if (y !== ey || c !== ec || led !== model_led()) begin
                errors++;
                $display("FAIL random %0d in=%0d: got %0d clip %0b led %0b required %0d clip %0b led %0b",
                         i, s, y, c, led, ey, ec, model_led());
            end
        end
    endtask

    task automatic test_reset_mid();
        int y, ey, lat, hits;
        bit c, ec, led, p;
        prime(16384);
        send(5000, 16384, 1'b0, y, c, led, lat, p);
        model_step(5000, 16384, ey, ec);
        checks++;
        if (y !== 5000) begin
            errors++; $display("FAIL pre_reset: got %0d required 5000", y);
        end
        @(negedge clk_144);
        gainIn = 16'sd1234; target_gain = 16'd16384; in_valid = 1'b1;
        @(negedge clk_144);
        in_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || gainOut !== 16'sd0) begin
            errors++;
            $display("FAIL async_reset: ready %0b out_valid %0b out %0d required 1 0 0", in_ready, out_valid, gainOut);
        end
        model_reset();
        hits = 0;
        repeat (2) begin
            @(negedge clk_144);
            if (out_valid) hits++;
        end
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_144);
            if (out_valid) hits++;
        end
        checks++;
        if (hits !== 0 || in_ready !== 1'b1 || clip_led !== 1'b0 || gainOut !== 16'sd0) begin
            errors++;
            $display("FAIL mid_reset_discard: strobes %0d ready %0b led %0b out %0d required 0 1 0 0",
                     hits, in_ready, clip_led, gainOut);
        end
        for (int i = 0; i < 2; i++) begin
            send(1000, 16384, 1'b0, y, c, led, lat, p);
            model_step(1000, 16384, ey, ec);
            checks++;
            if (y !== ey) begin
                errors++; $display("FAIL post_reset_gain sample %0d: got %0d required %0d", i, y, ey);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_unity();
        test_rounding();
        test_clip();
        test_handshake();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
